tf32_mul_arbiter: RTL

- Shares one combinational TF32_mul datapath between NUM_REQ independent requesters.
- Uses round-robin arbitration, a two-stage register pipeline (operand stage, result stage), valid/ready handshakes on both sides, and a returned requester ID per result.
- Sits between the matrix/PE control logic and the single TF32 multiplier so several lanes can time-share it at one op per cycle.

---
 rtl/tf32_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/tf32_mul.sv | 49 ++++
 rtl/tf32_mul_arbiter.sv | 105 ++++++++++
 4 files changed

// File: rtl/tf32_pkg.sv
// rtl/tf32_pkg.sv - TF32 format constants shared by the multiplier and its arbiter
package tf32_pkg;
   localparam int TF32_W   = 19;
   localparam int EXP_W    = 8;
   localparam int MANT_W   = 10;
   localparam int EXP_BIAS = 127;

   localparam logic [TF32_W-1:0] TF32_POS_ONE = 19'h1FC00;
   localparam logic [TF32_W-1:0] TF32_POS_TWO = 19'h20000;
   localparam logic [TF32_W-1:0] TF32_NEG_ONE = 19'h5FC00;
   localparam logic [TF32_W-1:0] TF32_ZERO    = 19'h00000;

   // Largest finite magnitude; overflowing products saturate here
   localparam logic [EXP_W-1:0]  EXP_MAX_NORM  = 8'hFE;
   localparam logic [MANT_W-1:0] MANT_MAX_NORM = 10'h3FF;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic            en,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id
);

   always_comb begin
      logic found;
      int   idx;
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/tf32_mul.sv
// rtl/tf32_mul.sv - combinational TF32 multiplier, RNE rounding, saturating, flush-to-+0
module tf32_mul
   import tf32_pkg::*;
(
   input  logic [TF32_W-1:0] a,
   input  logic [TF32_W-1:0] b,
   output logic [TF32_W-1:0] p
);

   logic                        sign;
   logic [EXP_W-1:0]            ea;
   logic [EXP_W-1:0]            eb;
   logic [2*MANT_W+1:0]         prod;
   logic [MANT_W-1:0]           mant;
   logic                        guard;
   logic                        sticky;
   logic [MANT_W:0]             mant_r;
   logic signed [EXP_W+1:0]     exp_s;

   always_comb begin
      sign  = a[TF32_W-1] ^ b[TF32_W-1];
      ea    = a[TF32_W-2 -: EXP_W];
      eb    = b[TF32_W-2 -: EXP_W];
      prod  = {1'b1, a[MANT_W-1:0]} * {1'b1, b[MANT_W-1:0]};
      exp_s = (EXP_W+2)'(ea) + (EXP_W+2)'(eb) - (EXP_W+2)'(EXP_BIAS);
      // Hidden-bit product lies in [1,4); renormalise when it reached 2
      if (prod[2*MANT_W+1]) begin
         {mant, guard} = prod[2*MANT_W -: MANT_W+1];
         sticky        = |prod[MANT_W-1:0];
         exp_s         = exp_s + (EXP_W+2)'(1);
      end else begin
         {mant, guard} = prod[2*MANT_W-1 -: MANT_W+1];
         sticky        = |prod[MANT_W-2:0];
      end
      mant_r = {1'b0, mant} + (MANT_W+1)'(guard & (sticky | mant[0]));
      if (mant_r[MANT_W]) begin
         exp_s = exp_s + (EXP_W+2)'(1);
      end
      // Zero/subnormal inputs and underflow collapse to +0
      if (ea == '0 || eb == '0 || exp_s <= 0) begin
         p = TF32_ZERO;
      end else if (exp_s >= 255) begin
         p = {sign, EXP_MAX_NORM, MANT_MAX_NORM};
      end else begin
         p = {sign, exp_s[EXP_W-1:0], mant_r[MANT_W-1:0]};
      end
   end

endmodule

// File: rtl/tf32_mul_arbiter.sv
// rtl/tf32_mul_arbiter.sv - round-robin sharing of one TF32 multiplier, two-stage pipeline
module tf32_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TF32_W  = 19,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*TF32_W-1:0] req_a,
   input  logic [NUM_REQ*TF32_W-1:0] req_b,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [TF32_W-1:0]         res_data,
   output logic [ID_W-1:0]           res_id,
   output logic [CNT_W-1:0]          op_cnt
);

   logic                s1_valid;
   logic [TF32_W-1:0]   s1_a;
   logic [TF32_W-1:0]   s1_b;
   logic [ID_W-1:0]     s1_id;
   logic [ID_W-1:0]     rr_ptr;
   logic [NUM_REQ-1:0]  gnt;
   logic [ID_W-1:0]     gnt_id;
   logic [ID_W-1:0]     ptr_next;
   logic [TF32_W-1:0]   prod;
   logic                stall2;
   logic                s1_ready;
   logic                arb_en;
   logic                xfer;

   assign stall2    = res_valid & ~res_ready;
   assign s1_ready  = ~s1_valid | ~stall2;
   // Nothing is granted while held in reset or flushing
   assign arb_en    = s1_ready & ~clr & ~rst;
   assign xfer      = |gnt;
   assign req_ready = gnt;
   assign ptr_next  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

   rr_arbiter #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_arb (
      .req    (req_valid),
      .en     (arb_en),
      .ptr    (rr_ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   tf32_mul u_mul (
      .a (s1_a),
      .b (s1_b),
      .p (prod)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_id    <= '0;
         rr_ptr   <= '0;
      end else if (clr) begin
         s1_valid <= 1'b0;
         rr_ptr   <= '0;
      end else if (xfer) begin
         s1_valid <= 1'b1;
         s1_a     <= req_a[int'(gnt_id)*TF32_W +: TF32_W];
         s1_b     <= req_b[int'(gnt_id)*TF32_W +: TF32_W];
         s1_id    <= gnt_id;
         rr_ptr   <= ptr_next;
      end else if (!stall2) begin
         s1_valid <= 1'b0;
      end
   end

   // Result stage: a flush drops the valid but leaves the last data visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
      end else if (clr) begin
         res_valid <= 1'b0;
      end else if (!stall2) begin
         res_valid <= s1_valid;
         res_data  <= prod;
         res_id    <= s1_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_cnt <= '0;
      end else if (res_valid && res_ready) begin
         op_cnt <= op_cnt + CNT_W'(1);
      end
   end

endmodule
